// File: rtl/decoder3x8_if.sv
// ============================================================================
// Module : decoder3x8_if
// Desc   : Select/decode bus between index producer and the registered decoder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface decoder3x8_if;
    logic       en;
    logic [2:0] sel;
    logic [7:0] y;
    logic       valid;

    // master produces the index and consumes the one-hot strobe
    modport master (output en, output sel, input y, input valid);
    modport slave  (input en, input sel, output y, output valid);
endinterface

`default_nettype wire

// File: rtl/decoder3x8.sv
// ============================================================================
// Module : decoder3x8
// Desc   : Registered 3-to-8 one-hot decoder with valid flag.
//          Define DECODER3X8_HOLD_EN to hold the last decode while en=0;
//          otherwise outputs clear to a single-cycle strobe.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module decoder3x8 (
    input  wire          clk,
    input  wire          rst,
    decoder3x8_if.slave  bus
);

    localparam logic [7:0] c_ONE_HOT_BASE = 8'b0000_0001;

    logic [7:0] r_y;
    logic       r_valid;
    logic [7:0] w_y_next;

    assign w_y_next = c_ONE_HOT_BASE << bus.sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y     <= 8'h00;
            r_valid <= 1'b0;
        end else if (bus.en) begin
            r_y     <= w_y_next;
            r_valid <= 1'b1;
        end else begin
`ifdef DECODER3X8_HOLD_EN
            r_y     <= r_y;
            r_valid <= r_valid;
`else
            r_y     <= 8'h00;
            r_valid <= 1'b0;
`endif
        end
    end

    assign bus.y     = r_y;
    assign bus.valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_decoder3x8.sv
// ============================================================================
// Module : tb_decoder3x8
// Desc   : Directed vector-table bench for decoder3x8 (both build variants).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_decoder3x8;

    typedef struct {
        logic       rst;
        logic       en;
        logic [2:0] sel;
        logic [7:0] exp_y;
        logic       exp_valid;
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    decoder3x8_if bus ();

    decoder3x8 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vec_t vec[$];

    function automatic vec_t mk(logic r, logic e, logic [2:0] s, logic [7:0] y, logic v);
        vec_t t;
        t.rst = r; t.en = e; t.sel = s; t.exp_y = y; t.exp_valid = v;
        return t;
    endfunction

    task automatic check(string name, int idx, logic [7:0] y_want, logic v_want);
        total++;
        if (bus.y !== y_want || bus.valid !== v_want) begin
            bad++;
            $display("FAIL %s[%0d]: y=%h valid=%b, want y=%h valid=%b",
                     name, idx, bus.y, bus.valid, y_want, v_want);
        end
        // y must be zero while invalid, exactly one-hot while valid
        total++;
        if ((bus.valid === 1'b1 && $countones(bus.y) != 1) ||
            (bus.valid === 1'b0 && bus.y !== 8'h00)) begin
            bad++;
            $display("FAIL %s_onehot[%0d]: y=%h valid=%b, want one-hot iff valid",
                     name, idx, bus.y, bus.valid);
        end
    endtask

    task automatic drive(logic r, logic e, logic [2:0] s);
        rst     = r;
        bus.en  = e;
        bus.sel = s;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        drive(1'b1, 1'b1, 3'd5);

        // reset held two edges with en=1, sel=5
        vec.push_back(mk(1, 1, 3'd5, 8'h00, 0));
        vec.push_back(mk(1, 1, 3'd5, 8'h00, 0));
        // exhaustive sweep, back-to-back
        vec.push_back(mk(0, 1, 3'd0, 8'h01, 1));
        vec.push_back(mk(0, 1, 3'd1, 8'h02, 1));
        vec.push_back(mk(0, 1, 3'd2, 8'h04, 1));
        vec.push_back(mk(0, 1, 3'd3, 8'h08, 1));
        vec.push_back(mk(0, 1, 3'd4, 8'h10, 1));
        vec.push_back(mk(0, 1, 3'd5, 8'h20, 1));
        vec.push_back(mk(0, 1, 3'd6, 8'h40, 1));
        vec.push_back(mk(0, 1, 3'd7, 8'h80, 1));
        // disable after decoding 3
        vec.push_back(mk(0, 1, 3'd3, 8'h08, 1));
`ifdef DECODER3X8_HOLD_EN
        vec.push_back(mk(0, 0, 3'd6, 8'h08, 1));
        vec.push_back(mk(0, 0, 3'd1, 8'h08, 1));
`else
        vec.push_back(mk(0, 0, 3'd6, 8'h00, 0));
        vec.push_back(mk(0, 0, 3'd1, 8'h00, 0));
`endif
        // mid-stream reset then immediate decode on release
        vec.push_back(mk(0, 1, 3'd7, 8'h80, 1));
        vec.push_back(mk(1, 1, 3'd7, 8'h00, 0));
        vec.push_back(mk(0, 1, 3'd2, 8'h04, 1));
`ifdef DECODER3X8_HOLD_EN
        vec.push_back(mk(0, 0, 3'd5, 8'h04, 1));
`else
        vec.push_back(mk(0, 0, 3'd5, 8'h00, 0));
`endif
        // reset while disabled must still clear
        vec.push_back(mk(1, 0, 3'd5, 8'h00, 0));

        @(negedge clk);
        foreach (vec[i]) begin
            drive(vec[i].rst, vec[i].en, vec[i].sel);
            @(posedge clk);
            #1;
            check("vec", i, vec[i].exp_y, vec[i].exp_valid);
            @(negedge clk);
        end

        // latency: sel change between edges must not reach y before the edge
        drive(1'b0, 1'b1, 3'd0);
        @(posedge clk);
        #1;
        check("lat_base", 0, 8'h01, 1'b1);
        #2;
        bus.sel = 3'd4;
        #1;
        check("lat_hold", 0, 8'h01, 1'b1);
        @(negedge clk);
        check("lat_hold", 1, 8'h01, 1'b1);
        @(posedge clk);
        #1;
        check("lat_new", 0, 8'h10, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
